// File: rtl/led_sweep_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : led_sweep_driver_if
// Description : Strobe/switch inputs and LED plane outputs of the sweep driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_sweep_driver_if #(
    parameter int NB_LEDS  = 5,
    parameter int NB_SW    = 4,
    parameter int NB_SWEEP = 8
);
    logic                i_valid;
    logic [NB_SW-1:0]    i_sw;
    logic [NB_LEDS-1:0]  o_led;
    logic [NB_LEDS-1:0]  o_led_b;
    logic [NB_LEDS-1:0]  o_led_g;
    logic                o_wrap;
    logic [NB_SWEEP-1:0] o_sweeps;

    modport master (
        output i_valid, i_sw,
        input  o_led, o_led_b, o_led_g, o_wrap, o_sweeps
    );

    modport slave (
        input  i_valid, i_sw,
        output o_led, o_led_b, o_led_g, o_wrap, o_sweeps
    );
endinterface
`default_nettype wire

// File: rtl/led_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_sweep_driver
// Description : One-hot LED sweep advanced by rate strobes, routed to a plane.
//               Optional ping-pong mode enabled by LED_SWEEP_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sweep_driver #(
    parameter int NB_LEDS  = 5,
    parameter int NB_SW    = 4,
    parameter int NB_SWEEP = 8
) (
    input  wire logic         clock,
    input  wire logic         i_reset,
    led_sweep_driver_if.slave bus
);

`ifdef LED_SWEEP_BOUNCE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_L  = 2'd1,
        RUN_R  = 2'd2,
        BOUNCE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_L  = 2'd1,
        RUN_R  = 2'd2
    } state_t;
`endif

    localparam logic [NB_LEDS-1:0] c_pat_rst = {{(NB_LEDS-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [NB_LEDS-1:0]  r_pat;
    logic [NB_LEDS-1:0]  r_led;
    logic [NB_LEDS-1:0]  r_led_b;
    logic [NB_LEDS-1:0]  r_led_g;
    logic                r_wrap;
    logic [NB_SWEEP-1:0] r_sweeps;

    state_t              w_next_state;
    logic                w_accept;
    logic [NB_LEDS-1:0]  w_pat_next;
    logic                w_wrap;
    logic [1:0]          w_sel;

`ifdef LED_SWEEP_BOUNCE_EN
    logic                r_up;
    logic                w_up_eff;
    logic                w_up_next;
`endif

    assign w_sel = bus.i_sw[3:2];

    always_comb begin
        w_next_state = IDLE;
        if (bus.i_sw[0]) begin
`ifdef LED_SWEEP_BOUNCE_EN
            if (bus.i_sw[1] && (w_sel == 2'b11))
                w_next_state = BOUNCE;
            else
`endif
            if (bus.i_sw[1])
                w_next_state = RUN_R;
            else
                w_next_state = RUN_L;
        end
    end

    assign w_accept = bus.i_valid && (r_state != IDLE);

    always_comb begin
        w_pat_next = r_pat;
        w_wrap     = 1'b0;
`ifdef LED_SWEEP_BOUNCE_EN
        // At an end bit the only legal move is away from it, whatever r_up says.
        w_up_eff   = r_pat[NB_LEDS-1] ? 1'b0 : (r_pat[0] ? 1'b1 : r_up);
        w_up_next  = r_up;
`endif
        if (!$onehot(r_pat)) begin
            w_pat_next = c_pat_rst;
        end else if (w_accept) begin
            case (r_state)
                RUN_L: begin
                    w_pat_next = {r_pat[NB_LEDS-2:0], r_pat[NB_LEDS-1]};
                    w_wrap     = r_pat[NB_LEDS-1];
                end
                RUN_R: begin
                    w_pat_next = {r_pat[0], r_pat[NB_LEDS-1:1]};
                    w_wrap     = r_pat[0];
                end
`ifdef LED_SWEEP_BOUNCE_EN
                BOUNCE: begin
                    w_pat_next = w_up_eff ? (r_pat << 1) : (r_pat >> 1);
                    w_wrap     = w_up_eff ? w_pat_next[NB_LEDS-1] : w_pat_next[0];
                    w_up_next  = w_wrap ? ~w_up_eff : w_up_eff;
                end
`endif
                default: begin
                    w_pat_next = r_pat;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_pat    <= c_pat_rst;
            r_led    <= c_pat_rst;
            r_led_b  <= '0;
            r_led_g  <= '0;
            r_wrap   <= 1'b0;
            r_sweeps <= '0;
`ifdef LED_SWEEP_BOUNCE_EN
            r_up     <= 1'b1;
`endif
        end else begin
            r_state  <= w_next_state;
            r_pat    <= w_pat_next;
            r_wrap   <= w_wrap;
            r_sweeps <= r_sweeps + {{(NB_SWEEP-1){1'b0}}, w_wrap};
            // Route the post-advance pattern so data and plane changes share one cycle of latency.
            r_led    <= ((w_sel == 2'b00) || (w_sel == 2'b11)) ? w_pat_next : '0;
            r_led_b  <= ((w_sel == 2'b01) || (w_sel == 2'b11)) ? w_pat_next : '0;
            r_led_g  <= ((w_sel == 2'b10) || (w_sel == 2'b11)) ? w_pat_next : '0;
`ifdef LED_SWEEP_BOUNCE_EN
            r_up     <= w_up_next;
`endif
        end
    end

    assign bus.o_led    = r_led;
    assign bus.o_led_b  = r_led_b;
    assign bus.o_led_g  = r_led_g;
    assign bus.o_wrap   = r_wrap;
    assign bus.o_sweeps = r_sweeps;

endmodule
`default_nettype wire

// File: tb/tb_led_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sweep_driver
// Description : Self-checking bench for led_sweep_driver (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sweep_driver;
    localparam int NB_LEDS  = 5;
    localparam int NB_SW    = 4;
    localparam int NB_SWEEP = 8;

    logic clock   = 1'b0;
    logic i_reset = 1'b0;
    always #5 clock = ~clock;

    led_sweep_driver_if #(.NB_LEDS(NB_LEDS), .NB_SW(NB_SW), .NB_SWEEP(NB_SWEEP)) bus();

    led_sweep_driver #(.NB_LEDS(NB_LEDS), .NB_SW(NB_SW), .NB_SWEEP(NB_SWEEP)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int errors    = 0;
    int checks    = 0;
    int wrap_seen = 0;
    bit cmp_en    = 1'b0;

    // Model: lit position as an integer, mode 0=idle 1=left 2=right.
    int m_pos    = 0;
    int m_mode   = 0;
    int m_sweeps = 0;
    int m_sel    = 0;
    bit m_wrap   = 1'b0;

    always @(posedge clock) begin
        if (!i_reset) begin
            m_pos = 0; m_mode = 0; m_sweeps = 0; m_sel = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (bus.i_valid && m_mode == 1) begin
                if (m_pos == NB_LEDS-1) begin m_pos = 0; m_wrap = 1'b1; end
                else m_pos = m_pos + 1;
            end else if (bus.i_valid && m_mode == 2) begin
                if (m_pos == 0) begin m_pos = NB_LEDS-1; m_wrap = 1'b1; end
                else m_pos = m_pos - 1;
            end
            if (m_wrap) m_sweeps = (m_sweeps + 1) % (1 << NB_SWEEP);
            m_mode = !bus.i_sw[0] ? 0 : (bus.i_sw[1] ? 2 : 1);
            m_sel  = int'(bus.i_sw[3:2]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [NB_LEDS-1:0] exp_pat;
        if (cmp_en) begin
            exp_pat = NB_LEDS'(1 << m_pos);
            check("led",    32'(bus.o_led),   32'((m_sel == 0 || m_sel == 3) ? exp_pat : '0));
            check("led_b",  32'(bus.o_led_b), 32'((m_sel == 1 || m_sel == 3) ? exp_pat : '0));
            check("led_g",  32'(bus.o_led_g), 32'((m_sel == 2 || m_sel == 3) ? exp_pat : '0));
            check("wrap",   32'(bus.o_wrap),  32'(m_wrap));
            check("sweeps", 32'(bus.o_sweeps), 32'(m_sweeps));
            if (bus.o_wrap === 1'b1) wrap_seen++;
        end
    end

    task automatic step(input bit v, input logic [3:0] sw, input bit rn);
        bus.i_valid = v;
        bus.i_sw    = sw;
        i_reset     = rn;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    logic [NB_LEDS-1:0] left_exp [5];

    initial begin
        left_exp[0] = 5'b00010; left_exp[1] = 5'b00100; left_exp[2] = 5'b01000;
        left_exp[3] = 5'b10000; left_exp[4] = 5'b00001;
        bus.i_valid = 1'b0;
        bus.i_sw    = '0;
        cmp_en      = 1'b1;

        for (int c = 0; c < 3; c++) step(c[0], 4'b0001, 1'b0);
        check("rst_led",    32'(bus.o_led),    32'h01);
        check("rst_led_b",  32'(bus.o_led_b),  32'h00);
        check("rst_led_g",  32'(bus.o_led_g),  32'h00);
        check("rst_wrap",   32'(bus.o_wrap),   32'h0);
        check("rst_sweeps", 32'(bus.o_sweeps), 32'h0);

        wrap_seen = 0;
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0001, 1'b1);
            check("left_led",  32'(bus.o_led),  32'(left_exp[i]));
            check("left_wrap", 32'(bus.o_wrap), 32'(i == 4));
            step(1'b0, 4'b0001, 1'b1);
            step(1'b0, 4'b0001, 1'b1);
        end
        check("left_sweeps", 32'(bus.o_sweeps), 32'd1);
        check("left_wraps",  32'(wrap_seen),    32'd1);

        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0011, 1'b1);
        step(1'b1, 4'b0011, 1'b1);
        check("right_led",  32'(bus.o_led),  32'h10);
        check("right_wrap", 32'(bus.o_wrap), 32'h1);
        step(1'b0, 4'b0011, 1'b1);
        check("right_wrap_end", 32'(bus.o_wrap), 32'h0);
        repeat (4) step(1'b1, 4'b0011, 1'b1);
        check("right_led_end", 32'(bus.o_led), 32'h01);

        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 1'b1);
        repeat (2) step(1'b1, 4'b0001, 1'b1);
        step(1'b0, 4'b1000, 1'b1);
        repeat (4) step(1'b1, 4'b1000, 1'b1);
        check("idle_led_g", 32'(bus.o_led_g), 32'h04);
        check("idle_led",   32'(bus.o_led),   32'h00);
        check("idle_led_b", 32'(bus.o_led_b), 32'h00);

        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b1101, 1'b1);
        wrap_seen = 0;
        repeat (5 * 256) step(1'b1, 4'b1101, 1'b1);
        check("b2b_led",    32'(bus.o_led),    32'h01);
        check("b2b_led_b",  32'(bus.o_led_b),  32'h01);
        check("b2b_led_g",  32'(bus.o_led_g),  32'h01);
        check("b2b_sweeps", 32'(bus.o_sweeps), 32'd0);
        check("b2b_wraps",  32'(wrap_seen),    32'd256);

        step(1'b0, 4'b0001, 1'b1);
        repeat (8) step(1'b1, 4'b0001, 1'b1);
        check("mid_led_pre",    32'(bus.o_led),    32'h08);
        check("mid_sweeps_pre", 32'(bus.o_sweeps), 32'd1);
        step(1'b1, 4'b0001, 1'b0);
        check("mid_led",    32'(bus.o_led),    32'h01);
        check("mid_sweeps", 32'(bus.o_sweeps), 32'd0);
        check("mid_wrap",   32'(bus.o_wrap),   32'h0);
        step(1'b1, 4'b0001, 1'b1);
        check("mid_idle_led", 32'(bus.o_led), 32'h01);

        repeat (3000) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 63) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/led_sweep_driver.md
Name: led_sweep_driver

Overview:
- Consumer side of the rate-strobe interface driven by the switch-controlled counter.
- Each accepted strobe on i_valid advances a one-hot 5-bit pattern across the LED bank.
- The pattern is routed to the red, blue or green LED plane according to the switches.
- Sits in top between the counter's o_valid output and the o_led/o_led_b/o_led_g pins.

Parameters:
NB_LEDS, 5, width of each LED plane and of the internal pattern
NB_SW, 4, width of switch input
NB_SWEEP, 8, width of completed-sweep counter

Ports:
clock  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous reset, active-low (0 = reset)
i_valid  input  1  single-cycle advance strobe from the counter
i_sw  input  NB_SW  [0] run enable, [1] direction (0 = left/up, 1 = right/down), [3:2] plane select
o_led  output  NB_LEDS  red plane
o_led_b  output  NB_LEDS  blue plane
o_led_g  output  NB_LEDS  green plane
o_wrap  output  1  one-cycle pulse when the pattern wraps
o_sweeps  output  NB_SWEEP  count of wraps, modulo 2^NB_SWEEP

Behaviour:
- One clock domain. Reset is synchronous and active-low: i_reset=0 sampled on a rising edge resets the block. Reset has priority over every other input.
- Reset values:
  - pattern = 5'b00001, state = IDLE.
  - o_led = 5'b00001 (plane select taken as 00 during reset).
  - o_led_b = 0, o_led_g = 0, o_wrap = 0, o_sweeps = 0.
- FSM states IDLE, RUN_L, RUN_R; next state is evaluated every cycle from i_sw:
  - i_sw[0]=0 -> IDLE.
  - i_sw[0]=1, i_sw[1]=0 -> RUN_L.
  - i_sw[0]=1, i_sw[1]=1 -> RUN_R.
  - A switch change takes effect on the cycle after it is sampled. A strobe arriving in that same cycle uses the old state.
- Strobe acceptance: i_valid=1 while in RUN_L or RUN_R. In IDLE, strobes are ignored and the pattern holds.
- RUN_L accept: pattern rotates toward the MSB (bit4 -> bit0 wrap).
- RUN_R accept: pattern rotates toward the LSB (bit0 -> bit4 wrap).
- Wrap: an accept that moves the set bit across the bit4/bit0 boundary.
  - Pulses o_wrap for exactly one cycle.
  - Increments o_sweeps, which rolls over from 2^NB_SWEEP-1 to 0 silently.
- Latency: all outputs are registered and update on the edge where i_valid is accepted. The new pattern is visible the cycle after the strobe.
- Plane routing, registered, so a plane change appears 1 cycle later:
  - i_sw[3:2] = 00 -> o_led.
  - 01 -> o_led_b.
  - 10 -> o_led_g.
  - 11 -> all three planes.
  - Unselected planes drive 0.
- Back-to-back strobes: each cycle's strobe is accepted with no dead cycle.
- Pattern is always exactly one-hot. If an illegal value is ever detected, the next edge forces 5'b00001.
- Reset mid-sweep: pattern, counter and outputs return to reset values on that edge. The FSM restarts from IDLE.

Optional Feature:
- Macro: LED_SWEEP_BOUNCE_EN.
- Defined:
  - Adds state BOUNCE, entered when i_sw[0]=1 and i_sw[1]=1 while i_sw[3:2]=11. Otherwise the normal mapping applies.
  - In BOUNCE, the pattern ping-pongs: it reverses at bit4 and at bit0 instead of wrapping (…00010 -> 00001 -> 00010).
  - Each end-reversal counts as a wrap (o_wrap pulse, o_sweeps++).
  - Internal direction flag resets to "up".
- Not defined: no BOUNCE state; behaviour exactly as above.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with i_valid toggling -> o_led=00001, o_led_b=o_led_g=0, o_wrap=0, o_sweeps=0.
- Left sweep: i_sw=4'b0001, 5 strobes spaced 3 cycles -> o_led sequence 00010, 00100, 01000, 10000, 00001. Single o_wrap pulse on the 5th, o_sweeps=1.
- Right sweep: i_sw=4'b0011 from reset, 1 strobe -> o_led=10000, o_wrap=1 for one cycle; 4 more strobes -> 00001.
- Idle hold and plane switch: advance to 00100, then i_sw=4'b1000 with 4 strobes -> o_led_g=00100, others 0, pattern unchanged.
- Back-to-back and rollover: i_sw=4'b1101, i_valid held high 5*256 cycles -> all planes equal, o_sweeps returns to 0, 256 o_wrap pulses.
- Reset mid-operation: at pattern 01000 assert i_reset=0 for 1 cycle coinciding with i_valid -> pattern 00001, o_sweeps=0, no o_wrap.
- With LED_SWEEP_BOUNCE_EN, i_sw=4'b1111, 9 strobes -> 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010; o_wrap pulses after strobes 4 and 8.
